i2c_reg_bank: RTL and testbench

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_bank_pkg.sv | 42 ++++
 rtl/i2c_reg_bank_if.sv | 10 +
 rtl/i2c_sync_edge.sv | 52 +++++
 rtl/i2c_reg_bank.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// Shared definitions for the I2C register bank: register map, reset values,
// device ID and FSM state encoding.
package i2c_reg_bank_pkg;

   // Register map (4-bit pointer space)
   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_FDIV_LO = 4'h1;
   localparam logic [3:0] REG_FDIV_HI = 4'h2;
   localparam logic [3:0] REG_PATTERN = 4'h3;
   localparam logic [3:0] REG_INTV0   = 4'h4;
   localparam logic [3:0] REG_INTV1   = 4'h5;
   localparam logic [3:0] REG_INTV2   = 4'h6;
   localparam logic [3:0] REG_INTV3   = 4'h7;
   localparam logic [3:0] REG_ID      = 4'h8;

   // Reset values and read-only ID
   localparam logic [7:0]  CTRL_RST    = 8'h00;
   localparam logic [7:0]  HOLD_RST    = 8'h00;
   localparam logic [15:0] FDIV_RST    = 16'h00FF;
   localparam logic [7:0]  PATTERN_RST = 8'h00;
   localparam logic [7:0]  INTV_RST    = 8'h00;
   localparam logic [7:0]  ID_VALUE    = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RACK
   } state_t;

   // Pointer post-increment: the implemented map ends at the ID register,
   // so stepping past it returns to ctrl.
   function automatic logic [3:0] ptr_next(input logic [3:0] ptr);
      return (ptr == REG_ID) ? 4'h0 : ptr + 4'h1;
   endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// I2C pad-side bus: SCL and SDA as seen at the pads, plus the open-drain
// pull-down enable for SDA.
interface i2c_reg_bank_if;
   logic scl_in;
   logic sda_in;
   logic sda_oe;

   modport master (output scl_in, output sda_in, input sda_oe);
   modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_sync_edge.sv
// Brings SCL/SDA into the clksys domain and derives SCL edges and
// START/STOP conditions from the synchronized copies only.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clksys,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // Synchronizer chains plus one history flop each; reset to the idle-bus level.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clksys or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync[0] <= scl_in;
         sda_sync[0] <= sda_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_d <= scl_s;
         sda_d <= sda_s;
      end
   end

   assign scl_rise  =  scl_s & ~scl_d;
   assign scl_fall  = ~scl_s &  scl_d;
   // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
   assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
   assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C slave with a small register file driving the PWM generator.
// Write: ADDR(W) + pointer byte + data bytes. Read: ADDR(R) streams from pointer.
module i2c_reg_bank
   import i2c_reg_bank_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic          clksys,
   input  logic          rst,
   i2c_reg_bank_if.slave bus,
   output logic [7:0]    ctrl,
   output logic [15:0]   fre_div,
   output logic [7:0]    pattern,
   output logic [7:0]    interval0,
   output logic [7:0]    interval1,
   output logic [7:0]    interval2,
   output logic [7:0]    interval3,
   output logic          busy
);

   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] shift_reg;
   logic [7:0] tx_reg;
   logic [3:0] pointer;
   logic [7:0] fdiv_hold;
   logic       rw;
   logic       ack_phase;
   logic       master_ack;
   logic [7:0] rx_byte;
   logic [7:0] rd_byte;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clksys    (clksys),
      .rst       (rst),
      .scl_in    (bus.scl_in),
      .sda_in    (bus.sda_in),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // Byte completed by the bit being sampled on this SCL rise.
   assign rx_byte = {shift_reg, sda_s};

   // Read-back mux addressed by the pointer.
   // NOTE: assign a default first so no path through always_comb infers a latch.
   always_comb begin
      rd_byte = 8'h00;
      case (pointer)
         REG_CTRL:    rd_byte = ctrl;
         REG_FDIV_LO: rd_byte = fdiv_hold;
         REG_FDIV_HI: rd_byte = fre_div[15:8];
         REG_PATTERN: rd_byte = pattern;
         REG_INTV0:   rd_byte = interval0;
         REG_INTV1:   rd_byte = interval1;
         REG_INTV2:   rd_byte = interval2;
         REG_INTV3:   rd_byte = interval3;
         REG_ID:      rd_byte = ID_VALUE;
         default:     rd_byte = 8'h00;
      endcase
   end

   // Protocol FSM and register file; START/STOP pre-empt any state.
   always_ff @(posedge clksys or posedge rst) begin
      if (rst) begin
         // NOTE: the register file is a few flops, not a RAM, so it is reset explicitly.
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 7'd0;
         tx_reg     <= 8'd0;
         pointer    <= 4'h0;
         rw         <= 1'b0;
         ack_phase  <= 1'b0;
         master_ack <= 1'b0;
         bus.sda_oe <= 1'b0;
         busy       <= 1'b0;
         ctrl       <= CTRL_RST;
         fdiv_hold  <= HOLD_RST;
         fre_div    <= FDIV_RST;
         pattern    <= PATTERN_RST;
         interval0  <= INTV_RST;
         interval1  <= INTV_RST;
         interval2  <= INTV_RST;
         interval3  <= INTV_RST;
      end else if (stop_det) begin
         state      <= ST_IDLE;
         ack_phase  <= 1'b0;
         bus.sda_oe <= 1'b0;
         busy       <= 1'b0;
      end else if (start_det) begin
         state      <= ST_ADDR;
         bit_cnt    <= 3'd0;
         ack_phase  <= 1'b0;
         bus.sda_oe <= 1'b0;
         busy       <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: ;

            ST_ADDR: if (scl_rise) begin
               shift_reg <= rx_byte[6:0];
               bit_cnt   <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rw        <= rx_byte[0];
                  ack_phase <= 1'b0;
                  state     <= (rx_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IDLE;
               end
            end

            // First SCL fall drives ACK, second one ends the ACK clock.
            ST_ADDR_ACK: if (scl_fall) begin
               if (!ack_phase) begin
                  bus.sda_oe <= 1'b1;
                  ack_phase  <= 1'b1;
               end else begin
                  ack_phase <= 1'b0;
                  bit_cnt   <= 3'd0;
                  if (rw) begin
                     tx_reg     <= {rd_byte[6:0], 1'b0};
                     bus.sda_oe <= ~rd_byte[7];
                     state      <= ST_RDATA;
                  end else begin
                     bus.sda_oe <= 1'b0;
                     state      <= ST_PTR;
                  end
               end
            end

            ST_PTR: if (scl_rise) begin
               shift_reg <= rx_byte[6:0];
               bit_cnt   <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  pointer <= rx_byte[3:0];
                  state   <= ST_PTR_ACK;
               end
            end

            ST_PTR_ACK, ST_WACK: if (scl_fall) begin
               if (!ack_phase) begin
                  bus.sda_oe <= 1'b1;
                  ack_phase  <= 1'b1;
               end else begin
                  bus.sda_oe <= 1'b0;
                  ack_phase  <= 1'b0;
                  bit_cnt    <= 3'd0;
                  state      <= ST_WDATA;
               end
            end

            // Registers commit only once the full byte is in; aborted bytes never reach here.
            ST_WDATA: if (scl_rise) begin
               shift_reg <= rx_byte[6:0];
               bit_cnt   <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  case (pointer)
                     REG_CTRL:    ctrl      <= rx_byte;
                     REG_FDIV_LO: fdiv_hold <= rx_byte;
                     REG_FDIV_HI: fre_div   <= {rx_byte, fdiv_hold};
                     REG_PATTERN: pattern   <= rx_byte;
                     REG_INTV0:   interval0 <= rx_byte;
                     REG_INTV1:   interval1 <= rx_byte;
                     REG_INTV2:   interval2 <= rx_byte;
                     REG_INTV3:   interval3 <= rx_byte;
                     default: ;
                  endcase
                  pointer <= ptr_next(pointer);
                  state   <= ST_WACK;
               end
            end

            // MSB is already on the pad; each SCL fall presents the next bit.
            ST_RDATA: if (scl_rise) begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  pointer   <= ptr_next(pointer);
                  ack_phase <= 1'b0;
                  state     <= ST_RACK;
               end
            end else if (scl_fall) begin
               bus.sda_oe <= ~tx_reg[7];
               tx_reg     <= {tx_reg[6:0], 1'b0};
            end

            // Release SDA for the master's ACK, sample it, then continue or stop.
            ST_RACK: if (scl_fall) begin
               if (!ack_phase) begin
                  bus.sda_oe <= 1'b0;
                  ack_phase  <= 1'b1;
               end else if (master_ack) begin
                  tx_reg     <= {rd_byte[6:0], 1'b0};
                  bus.sda_oe <= ~rd_byte[7];
                  ack_phase  <= 1'b0;
                  bit_cnt    <= 3'd0;
                  state      <= ST_RDATA;
               end else begin
                  ack_phase <= 1'b0;
                  state     <= ST_IDLE;
               end
            end else if (scl_rise && ack_phase) begin
               master_ack <= ~sda_s;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: bit-banged I2C master, scoreboard of expected
// ACKs and read bytes, plus direct register checks.
module tb_i2c_reg_bank;

   localparam int Q = 8;   // clksys cycles per quarter SCL period

   logic        clksys = 1'b0;
   logic        rst    = 1'b1;
   logic        scl_m  = 1'b1;
   logic        sda_m  = 1'b1;
   logic [7:0]  ctrl, pattern, interval0, interval1, interval2, interval3;
   logic [15:0] fre_div;
   logic        busy;

   always #5 clksys = ~clksys;

   i2c_reg_bank_if bus ();
   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;   // wired-AND open-drain line

   i2c_reg_bank #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clksys    (clksys),
      .rst       (rst),
      .bus       (bus),
      .ctrl      (ctrl),
      .fre_div   (fre_div),
      .pattern   (pattern),
      .interval0 (interval0),
      .interval1 (interval1),
      .interval2 (interval2),
      .interval3 (interval3),
      .busy      (busy)
   );

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // fre_div change counter and sda_oe activity flag
   logic        fre_mon  = 1'b0;
   logic [15:0] fre_prev;
   int          fre_chg  = 0;
   logic        oe_mon   = 1'b0;
   logic        oe_seen  = 1'b0;

   always @(negedge clksys) begin
      if (fre_mon && (fre_div !== fre_prev)) fre_chg <= fre_chg + 1;
      fre_prev <= fre_div;
      if (oe_mon && bus.sda_oe) oe_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(posedge clksys);
      #1;
   endtask

   task automatic clock_bit(input logic b, output logic line);
      sda_m = b;
      qwait();
      scl_m = 1'b1;
      qwait();
      line = bus.sda_in;
      qwait();
      scl_m = 1'b0;
      qwait();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      qwait();
      scl_m = 1'b1;
      qwait();
      sda_m = 1'b0;
      qwait();
      scl_m = 1'b0;
      qwait();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      qwait();
      scl_m = 1'b1;
      qwait();
      sda_m = 1'b1;
      qwait();
      qwait();
   endtask

   task automatic sb_push(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [7:0] got);
      exp_t e;
      check("sb_has_expectation", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ack);
      logic l;
      sb_push(tag, {7'b0, exp_ack});
      for (int i = 7; i >= 0; i--) clock_bit(d[i], l);
      clock_bit(1'b1, l);
      sb_pop({7'b0, ~l});
   endtask

   task automatic read_byte(input string tag, input logic [7:0] exp, input logic ack);
      logic       l;
      logic [7:0] d;
      d = 8'h00;
      sb_push(tag, exp);
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, l);
         d = {d[6:0], l};
      end
      clock_bit(~ack, l);
      sb_pop(d);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_ctrl"},    ctrl,       8'h00);
      check({pfx, "_fre_div"}, fre_div,    16'h00FF);
      check({pfx, "_pattern"}, pattern,    8'h00);
      check({pfx, "_intv0"},   interval0,  8'h00);
      check({pfx, "_intv1"},   interval1,  8'h00);
      check({pfx, "_intv2"},   interval2,  8'h00);
      check({pfx, "_intv3"},   interval3,  8'h00);
      check({pfx, "_sda_oe"},  bus.sda_oe, 1'b0);
      check({pfx, "_busy"},    busy,       1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic l;

      // Reset state
      repeat (5) @(posedge clksys);
      #1;
      check_reset_values("rst");
      rst = 1'b0;
      qwait();
      check_reset_values("post_rst");

      // Single write: ctrl = 0x01
      i2c_start();
      check("busy_after_start", busy, 1'b1);
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr0",   8'h00, 1'b1);
      write_byte("ack_ctrl",   8'h01, 1'b1);
      check("ctrl_written", ctrl, 8'h01);
      check("busy_before_stop", busy, 1'b1);
      i2c_stop();
      check("busy_after_stop", busy, 1'b0);
      check("sda_oe_after_stop", bus.sda_oe, 1'b0);

      // Burst write from 0x1; fre_div must jump straight from 00FF to 1234
      fre_mon = 1'b1;
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr1",   8'h01, 1'b1);
      write_byte("ack_lo",     8'h34, 1'b1);
      check("fre_div_held", fre_div, 16'h00FF);
      write_byte("ack_hi",     8'h12, 1'b1);
      check("fre_div_loaded", fre_div, 16'h1234);
      write_byte("ack_pat",    8'hAA, 1'b1);
      write_byte("ack_i0",     8'h05, 1'b1);
      write_byte("ack_i1",     8'h06, 1'b1);
      write_byte("ack_i2",     8'h07, 1'b1);
      write_byte("ack_i3",     8'h08, 1'b1);
      i2c_stop();
      fre_mon = 1'b0;
      check("fre_div_changes", fre_chg, 1);
      check("pattern", pattern, 8'hAA);
      check("intv0", interval0, 8'h05);
      check("intv1", interval1, 8'h06);
      check("intv2", interval2, 8'h07);
      check("intv3", interval3, 8'h08);

      // Pointer 0x7, repeated START, read across the ID register and wrap
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr7",   8'h07, 1'b1);
      i2c_start();
      write_byte("ack_addr_r", 8'hA1, 1'b1);
      read_byte("rd_intv3", 8'h08, 1'b1);
      read_byte("rd_id",    8'hA5, 1'b1);
      read_byte("rd_wrap",  8'h01, 1'b0);
      check("sda_released_after_nack", bus.sda_oe, 1'b0);
      i2c_stop();

      // Write to 0x9 is ACKed and discarded; 0xA reads as zero
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr9",   8'h09, 1'b1);
      write_byte("ack_ro",     8'h77, 1'b1);
      i2c_start();
      write_byte("ack_addr_r", 8'hA1, 1'b1);
      read_byte("rd_unmapped", 8'h00, 1'b0);
      i2c_stop();

      // 0x1 reads back the holding byte, 0x2 the fre_div high byte
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr1",   8'h01, 1'b1);
      i2c_start();
      write_byte("ack_addr_r", 8'hA1, 1'b1);
      read_byte("rd_hold", 8'h34, 1'b1);
      read_byte("rd_fhi",  8'h12, 1'b0);
      i2c_stop();
      check("ctrl_kept", ctrl, 8'h01);

      // Wrong address: no ACK, SDA never driven, registers untouched
      oe_mon = 1'b1;
      i2c_start();
      write_byte("nack_addr_51", 8'hA2, 1'b0);
      write_byte("nack_data",    8'h00, 1'b0);
      i2c_stop();
      oe_mon = 1'b0;
      check("oe_never_driven", oe_seen, 1'b0);
      check("ctrl_unchanged_51", ctrl, 8'h01);
      check("fre_div_unchanged_51", fre_div, 16'h1234);

      // STOP after 4 data bits: partial byte discarded
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr3",   8'h03, 1'b1);
      clock_bit(1'b0, l);
      clock_bit(1'b1, l);
      clock_bit(1'b0, l);
      clock_bit(1'b1, l);
      i2c_stop();
      check("pattern_after_abort", pattern, 8'hAA);
      check("busy_after_abort", busy, 1'b0);
      check("sda_oe_after_abort", bus.sda_oe, 1'b0);

      // Reset asserted while the slave is driving a read bit
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr0",   8'h00, 1'b1);
      i2c_start();
      write_byte("ack_addr_r", 8'hA1, 1'b1);
      clock_bit(1'b1, l);
      clock_bit(1'b1, l);
      check("sda_oe_driving_bit5", bus.sda_oe, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      repeat (3) @(posedge clksys);
      #1;
      rst = 1'b0;
      i2c_stop();
      check("busy_idle_after_rst", busy, 1'b0);
      check("sda_oe_idle_after_rst", bus.sda_oe, 1'b0);

      // Pointer restarted at 0; holding byte back at reset value
      i2c_start();
      write_byte("ack_addr_r", 8'hA1, 1'b1);
      read_byte("rd_ctrl_rst", 8'h00, 1'b1);
      read_byte("rd_hold_rst", 8'h00, 1'b0);
      i2c_stop();

      // Bus still functional after reset
      i2c_start();
      write_byte("ack_addr_w", 8'hA0, 1'b1);
      write_byte("ack_ptr0",   8'h00, 1'b1);
      write_byte("ack_ctrl",   8'h5A, 1'b1);
      i2c_stop();
      check("ctrl_after_rst", ctrl, 8'h5A);
      check("fre_div_after_rst", fre_div, 16'h00FF);

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
